// File: rtl/sudoku_pkg.sv
// Shared types and constants for the 4x4 sudoku input controller.
package sudoku_pkg;

    localparam int NCELL   = 16;
    localparam int CELL_W  = 4;
    localparam int VAL_MAX = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEEK   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// single-cycle pulse on each debounced rising edge.
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clka,
    input  logic restart_n,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          pulse_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            pulse_q <= 1'b0;
            if (sync2_q != level_q) begin
                // The level flips on the DEB_CYCLES-th consecutive disagreement.
                if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                    level_q <= sync2_q;
                    pulse_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/sudoku_input_ctrl.sv
// Button front end for the board datapath: cursor movement that skips hint
// cells, candidate value cycling and a one-cycle commit strobe.
module sudoku_input_ctrl
    import sudoku_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int NCELL      = 16
) (
    input  logic             clka,
    input  logic             restart_n,
    input  logic             input_en,
    input  logic             btn_next,
    input  logic             btn_val,
    input  logic             btn_enter,
    input  logic [NCELL-1:0] fill_flag,
    output logic [3:0]       reg_choose,
    output logic [2:0]       value_inp,
    output logic             register_inp_flag,
    output logic             seek_busy
);

    logic ev_next;
    logic ev_val;
    logic ev_enter;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
        .clka(clka), .restart_n(restart_n), .btn_i(btn_next), .pulse_o(ev_next)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_val (
        .clka(clka), .restart_n(restart_n), .btn_i(btn_val), .pulse_o(ev_val)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_enter (
        .clka(clka), .restart_n(restart_n), .btn_i(btn_enter), .pulse_o(ev_enter)
    );

    state_e              state_q;
    logic [CELL_W-1:0]   reg_choose_q;
    logic [2:0]          value_q;
    logic                strobe_q;
    logic                busy_q;
    logic [CELL_W:0]     step_q;
    logic [CELL_W-1:0]   cursor_inc;

    assign cursor_inc = reg_choose_q + 1'b1;

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state_q      <= ST_IDLE;
            reg_choose_q <= '0;
            value_q      <= '0;
            strobe_q     <= 1'b0;
            busy_q       <= 1'b0;
            step_q       <= '0;
        end else if (!input_en) begin
            state_q  <= ST_IDLE;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Enter outranks next, next outranks val; losers are dropped.
                    if (ev_enter) begin
                        if (!fill_flag[reg_choose_q]) begin
                            state_q  <= ST_COMMIT;
                            strobe_q <= 1'b1;
                        end
                    end else if (ev_next) begin
                        state_q <= ST_SEEK;
                        busy_q  <= 1'b1;
                        step_q  <= '0;
                    end else if (ev_val) begin
                        value_q <= (value_q == 3'(VAL_MAX)) ? 3'd0 : value_q + 3'd1;
                    end
                end
                ST_SEEK: begin
                    reg_choose_q <= cursor_inc;
                    step_q       <= step_q + 1'b1;
                    // A full lap ends the scan even when every cell is locked.
                    if (!fill_flag[cursor_inc] || step_q == (CELL_W + 1)'(NCELL - 1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_COMMIT: begin
                    state_q  <= ST_IDLE;
                    strobe_q <= 1'b0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    strobe_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign reg_choose        = reg_choose_q;
    assign value_inp         = value_q;
    assign register_inp_flag = strobe_q & input_en;
    assign seek_busy         = busy_q;

endmodule
